// File: rtl/ifft8_seq_pkg.sv
// ---------------------------------------------------------------------------
// ifft8_seq_pkg
//   Shared definitions for the sequential 8-point inverse FFT:
//   frame size, FSM state encoding, Q16 conjugate twiddle constants,
//   3-bit bit-reversal and the butterfly schedule decoder.
// ---------------------------------------------------------------------------
package ifft8_seq_pkg;

  localparam int N          = 8;   // points per frame
  localparam int CALC_STEPS = 12;  // 3 stages x 4 butterflies
  localparam int TW_W       = 18;  // signed width holding +/-65536

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CALC  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Q16 twiddles W_k = cos + j*sin for the inverse transform (positive sines).
  localparam logic signed [TW_W-1:0] COS0 = 18'sd65536;
  localparam logic signed [TW_W-1:0] SIN0 = 18'sd0;
  localparam logic signed [TW_W-1:0] COS1 = 18'sd46341;
  localparam logic signed [TW_W-1:0] SIN1 = 18'sd46341;
  localparam logic signed [TW_W-1:0] COS2 = 18'sd0;
  localparam logic signed [TW_W-1:0] SIN2 = 18'sd65536;
  localparam logic signed [TW_W-1:0] COS3 = -18'sd46341;
  localparam logic signed [TW_W-1:0] SIN3 = 18'sd46341;

  // Bank addresses and twiddle index for one butterfly step.
  typedef struct packed {
    logic [2:0] top;
    logic [2:0] bot;
    logic [1:0] k;
  } bfly_sel_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  function automatic logic signed [TW_W-1:0] tw_cos(input logic [1:0] k);
    case (k)
      2'd0:    return COS0;
      2'd1:    return COS1;
      2'd2:    return COS2;
      default: return COS3;
    endcase
  endfunction

  function automatic logic signed [TW_W-1:0] tw_sin(input logic [1:0] k);
    case (k)
      2'd0:    return SIN0;
      2'd1:    return SIN1;
      2'd2:    return SIN2;
      default: return SIN3;
    endcase
  endfunction

  // step[3:2] = stage s, step[1:0] = butterfly b within the stage.
  // span h = 2^s, j = b mod h, g = b / h, top = g*2h + j, k = j*4/h.
  function automatic bfly_sel_t bfly_sel(input logic [3:0] step);
    bfly_sel_t  sel;
    logic [1:0] b;
    b = step[1:0];
    case (step[3:2])
      2'd0: begin
        sel.top = {b, 1'b0};
        sel.bot = {b, 1'b1};
        sel.k   = 2'd0;
      end
      2'd1: begin
        sel.top = {b[1], 1'b0, b[0]};
        sel.bot = {b[1], 1'b1, b[0]};
        sel.k   = {b[0], 1'b0};
      end
      default: begin
        sel.top = {1'b0, b};
        sel.bot = {1'b1, b};
        sel.k   = b;
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ifft8_seq_bfly.sv
// ---------------------------------------------------------------------------
// ifft_bfly_sat
//   Combinational radix-2 DIT butterfly with a Q(FRAC) complex twiddle:
//     t = b * W          (skipped when bypass = 1, t = b exactly)
//     top = sat(a + t),  bot = sat(a - t)
//   Ports:
//     a_re/a_im, b_re/b_im : signed DW-bit operands
//     tw_c/tw_s            : signed Q(FRAC) twiddle cos/sin
//     bypass               : k = 0, pass b through without multiplying
//     top_*/bot_*          : saturated DW-bit results
//     sat                  : any of the four results saturated
// ---------------------------------------------------------------------------
module ifft_bfly_sat
  import ifft8_seq_pkg::*;
#(
  parameter int DW   = 32,
  parameter int FRAC = 16
) (
  input  logic signed [DW-1:0]   a_re,
  input  logic signed [DW-1:0]   a_im,
  input  logic signed [DW-1:0]   b_re,
  input  logic signed [DW-1:0]   b_im,
  input  logic signed [TW_W-1:0] tw_c,
  input  logic signed [TW_W-1:0] tw_s,
  input  logic                   bypass,
  output logic signed [DW-1:0]   top_re,
  output logic signed [DW-1:0]   top_im,
  output logic signed [DW-1:0]   bot_re,
  output logic signed [DW-1:0]   bot_im,
  output logic                   sat
);

  localparam int PW = 2*DW + 2;

  logic signed [PW-1:0] br_x, bi_x, c_x, s_x;
  logic signed [PW-1:0] prod_re, prod_im;
  logic signed [DW:0]   a_re_x, a_im_x, t_re, t_im;
  logic signed [DW:0]   sum_top_re, sum_top_im, sum_bot_re, sum_bot_im;

  function automatic logic ovf(input logic signed [DW:0] v);
    return v[DW] ^ v[DW-1];
  endfunction

  function automatic logic signed [DW-1:0] clamp(input logic signed [DW:0] v);
    if (ovf(v)) return {v[DW], {(DW-1){~v[DW]}}};
    else        return v[DW-1:0];
  endfunction

  assign br_x = {{(PW-DW){b_re[DW-1]}}, b_re};
  assign bi_x = {{(PW-DW){b_im[DW-1]}}, b_im};
  assign c_x  = {{(PW-TW_W){tw_c[TW_W-1]}}, tw_c};
  assign s_x  = {{(PW-TW_W){tw_s[TW_W-1]}}, tw_s};

  // Full-width sum of products, rounded by a single arithmetic shift.
  assign prod_re = br_x * c_x - bi_x * s_x;
  assign prod_im = br_x * s_x + bi_x * c_x;

  assign t_re = bypass ? {b_re[DW-1], b_re} : (DW+1)'(prod_re >>> FRAC);
  assign t_im = bypass ? {b_im[DW-1], b_im} : (DW+1)'(prod_im >>> FRAC);

  assign a_re_x = {a_re[DW-1], a_re};
  assign a_im_x = {a_im[DW-1], a_im};

  assign sum_top_re = a_re_x + t_re;
  assign sum_top_im = a_im_x + t_im;
  assign sum_bot_re = a_re_x - t_re;
  assign sum_bot_im = a_im_x - t_im;

  assign top_re = clamp(sum_top_re);
  assign top_im = clamp(sum_top_im);
  assign bot_re = clamp(sum_bot_re);
  assign bot_im = clamp(sum_bot_im);

  assign sat = ovf(sum_top_re) | ovf(sum_top_im) | ovf(sum_bot_re) | ovf(sum_bot_im);

endmodule

// File: rtl/ifft8_seq.sv
// ---------------------------------------------------------------------------
// ifft8_seq
//   Sequential 8-point radix-2 DIT inverse FFT, one butterfly per cycle
//   over an 8-entry complex register bank. No per-stage scaling.
//   Ports:
//     clk, rst_n          : clock (rising edge), async active-low reset
//     in_valid/in_ready   : input handshake, X[0..7] in order
//     in_re/in_im         : signed spectrum bin
//     out_valid/out_ready : output handshake, x[0..7] in natural order
//     out_re/out_im       : signed time sample (0 when out_valid = 0)
//     out_last            : high with x[7]
//     out_sat             : frame saw at least one saturation
//     busy                : computing or draining
// ---------------------------------------------------------------------------
module ifft8_seq
  import ifft8_seq_pkg::*;
#(
  parameter int DW   = 32,
  parameter int FRAC = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          out_last,
  output logic          out_sat,
  output logic          busy
);

  localparam logic [2:0] LAST_IDX  = 3'(N - 1);
  localparam logic [3:0] LAST_STEP = 4'(CALC_STEPS - 1);

  state_t     state, state_nxt;
  logic [2:0] load_cnt;
  logic [3:0] calc_cnt;
  logic [2:0] out_cnt;
  logic       sat_flag;

  logic signed [DW-1:0] bank_re [N];
  logic signed [DW-1:0] bank_im [N];

  logic                   in_fire, out_fire;
  bfly_sel_t              sel;
  logic signed [TW_W-1:0] tw_c, tw_s;
  logic signed [DW-1:0]   top_re, top_im, bot_re, bot_im;
  logic                   bfly_sat;

  // Handshakes decoded from the state register directly, so they do not
  // loop through the output logic below.
  assign in_fire  = in_valid  && (state == ST_LOAD);
  assign out_fire = out_ready && (state == ST_DRAIN);

  assign sel  = bfly_sel(calc_cnt);
  assign tw_c = tw_cos(sel.k);
  assign tw_s = tw_sin(sel.k);

  ifft_bfly_sat #(
    .DW   (DW),
    .FRAC (FRAC)
  ) u_bfly (
    .a_re   (bank_re[sel.top]),
    .a_im   (bank_im[sel.top]),
    .b_re   (bank_re[sel.bot]),
    .b_im   (bank_im[sel.bot]),
    .tw_c   (tw_c),
    .tw_s   (tw_s),
    .bypass (sel.k == 2'd0),
    .top_re (top_re),
    .top_im (top_im),
    .bot_re (bot_re),
    .bot_im (bot_im),
    .sat    (bfly_sat)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_sat   = 1'b0;
    out_re    = '0;
    out_im    = '0;
    busy      = 1'b0;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_fire && load_cnt == LAST_IDX) state_nxt = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (calc_cnt == LAST_STEP) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_re    = bank_re[out_cnt];
        out_im    = bank_im[out_cnt];
        out_last  = (out_cnt == LAST_IDX);
        out_sat   = sat_flag;
        if (out_fire && out_cnt == LAST_IDX) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_LOAD;
      load_cnt <= '0;
      calc_cnt <= '0;
      out_cnt  <= '0;
      sat_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_fire) load_cnt <= load_cnt + 3'd1;
      if (state == ST_CALC) calc_cnt <= (calc_cnt == LAST_STEP) ? 4'd0 : calc_cnt + 4'd1;
      if (out_fire) out_cnt <= out_cnt + 3'd1;
      // Cleared as the frame enters CALC, then sticky across the 12 steps.
      if (in_fire && load_cnt == LAST_IDX) sat_flag <= 1'b0;
      else if (state == ST_CALC && bfly_sat) sat_flag <= 1'b1;
    end
  end

  // NOTE: the bank is deliberately not reset; every entry is rewritten by
  // LOAD before CALC reads it, so reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      bank_re[bitrev3(load_cnt)] <= $signed(in_re);
      bank_im[bitrev3(load_cnt)] <= $signed(in_im);
    end else if (state == ST_CALC) begin
      // In-place write-back: the next step already sees these results.
      bank_re[sel.top] <= top_re;
      bank_im[sel.top] <= top_im;
      bank_re[sel.bot] <= bot_re;
      bank_im[sel.bot] <= bot_im;
    end
  end

endmodule

// File: tb/tb_ifft8_seq.sv
// ---------------------------------------------------------------------------
// tb_ifft8_seq
//   Self-checking bench for ifft8_seq. Expected samples are pushed to a
//   scoreboard queue when a frame is driven and popped as x[n] is accepted.
// ---------------------------------------------------------------------------
module tb_ifft8_seq;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re, in_im;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_re, out_im;
  logic          out_last;
  logic          out_sat;
  logic          busy;

  ifft8_seq #(.DW(DW), .FRAC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint re;
    longint im;
    bit     last;
    bit     sat;
  } exp_t;

  exp_t   sb_q[$];
  longint fr_re[8], fr_im[8];
  longint ex_re[8], ex_im[8];
  bit     ex_sat;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---- reference model: bit-exact DIT inverse FFT --------------------------
  function automatic longint wrap33(input longint v);
    logic signed [32:0] w;
    w = v[32:0];
    return longint'(w);
  endfunction

  function automatic longint sat32(input longint v, inout bit s);
    if (v > 64'sd2147483647)  begin s = 1'b1; return 64'sd2147483647;  end
    if (v < -64'sd2147483648) begin s = 1'b1; return -64'sd2147483648; end
    return v;
  endfunction

  function automatic void ifft_model(input longint xr[8], input longint xi[8],
                                     output longint yr[8], output longint yi[8],
                                     output bit sat);
    longint cw[4] = '{65536, 46341, 0, -46341};
    longint sw[4] = '{0, 46341, 65536, 46341};
    longint ar, ai, tr, ti;
    int     h, g, j, top, bot, k, rv;
    sat = 1'b0;
    for (int n = 0; n < 8; n++) begin
      rv = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
      yr[rv] = xr[n];
      yi[rv] = xi[n];
    end
    for (int s = 0; s < 3; s++) begin
      h = 1 << s;
      for (int b = 0; b < 4; b++) begin
        g = b / h; j = b % h;
        top = g * 2 * h + j; bot = top + h; k = j * 4 / h;
        if (k == 0) begin
          tr = yr[bot]; ti = yi[bot];
        end else begin
          tr = wrap33((yr[bot] * cw[k] - yi[bot] * sw[k]) >>> 16);
          ti = wrap33((yr[bot] * sw[k] + yi[bot] * cw[k]) >>> 16);
        end
        ar = yr[top]; ai = yi[top];
        yr[top] = sat32(wrap33(ar + tr), sat);
        yi[top] = sat32(wrap33(ai + ti), sat);
        yr[bot] = sat32(wrap33(ar - tr), sat);
        yi[bot] = sat32(wrap33(ai - ti), sat);
      end
    end
  endfunction

  // ---- stimulus / scoreboard helpers ---------------------------------------
  task automatic push_expected();
    for (int n = 0; n < 8; n++) sb_q.push_back('{ex_re[n], ex_im[n], n == 7, ex_sat});
  endtask

  task automatic clear_frame();
    for (int n = 0; n < 8; n++) begin
      fr_re[n] = 0; fr_im[n] = 0; ex_re[n] = 0; ex_im[n] = 0;
    end
    ex_sat = 1'b0;
  endtask

  // Called and returns at a negedge; each sample is held until accepted.
  task automatic send_frame();
    int w;
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1;
      in_re    = fr_re[n][31:0];
      in_im    = fr_im[n][31:0];
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      check($sformatf("in_ready_x%0d", n), longint'(in_ready), 1);
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
  endtask

  task automatic drain(input int stall_idx);
    int   w;
    exp_t e;
    check("idle_out_re", longint'($signed(out_re)), 0);
    w = 0;
    while (!out_valid && w < 100) begin @(negedge clk); w++; end
    check("latency", w, 12);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_idx) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_valid", longint'(out_valid), 1);
          check("stall_in_ready", longint'(in_ready), 0);
          check("stall_re", longint'($signed(out_re)), sb_q.size() > 0 ? sb_q[0].re : 64'sh7fff_ffff_ffff);
          check("stall_im", longint'($signed(out_im)), sb_q.size() > 0 ? sb_q[0].im : 64'sh7fff_ffff_ffff);
        end
        out_ready = 1'b1;
      end
      check($sformatf("valid_x%0d", i), longint'(out_valid), 1);
      if (sb_q.size() == 0) begin
        check("sb_underflow", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("re_x%0d", i),   longint'($signed(out_re)), e.re);
        check($sformatf("im_x%0d", i),   longint'($signed(out_im)), e.im);
        check($sformatf("last_x%0d", i), longint'(out_last), longint'(e.last));
        check($sformatf("sat_x%0d", i),  longint'(out_sat),  longint'(e.sat));
      end
      @(posedge clk); @(negedge clk);
    end
    check("post_valid", longint'(out_valid), 0);
    check("post_in_ready", longint'(in_ready), 1);
    check("post_busy", longint'(busy), 0);
  endtask

  task automatic load_x1();
    clear_frame();
    fr_re[1] = 65536;
    ex_re = '{65536, 46341, 0, -46341, -65536, -46341, 0, 46341};
    ex_im = '{0, 46341, 65536, 46341, 0, -46341, -65536, -46341};
  endtask

  task automatic random_frame(input int shift);
    int r;
    clear_frame();
    for (int n = 0; n < 8; n++) begin
      r = $urandom(); fr_re[n] = longint'(r) >>> shift;
      r = $urandom(); fr_im[n] = longint'(r) >>> shift;
    end
    ifft_model(fr_re, fr_im, ex_re, ex_im, ex_sat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy",      longint'(busy), 0);
    check("rst_out_last",  longint'(out_last), 0);
    check("rst_out_sat",   longint'(out_sat), 0);
    check("rst_out_re",    longint'($signed(out_re)), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 1);

    // all bins 8192 -> impulse of 65536 at x0
    clear_frame();
    for (int n = 0; n < 8; n++) fr_re[n] = 8192;
    ex_re[0] = 65536;
    push_expected(); send_frame(); drain(-1);

    // DC bin only -> constant output
    clear_frame();
    fr_re[0] = 1000; fr_im[0] = -500;
    for (int n = 0; n < 8; n++) begin ex_re[n] = 1000; ex_im[n] = -500; end
    push_expected(); send_frame(); drain(-1);

    // X1 unit tone with 3-cycle stall on x2
    load_x1();
    push_expected(); send_frame(); drain(2);

    // back-to-back saturating frame
    clear_frame();
    for (int n = 0; n < 8; n++) fr_re[n] = 64'sd1073741824;
    ex_re[0] = 2147483647;
    ex_sat   = 1'b1;
    push_expected(); send_frame(); drain(-1);

    // reset during CALC cycle 5 abandons the frame
    load_x1();
    send_frame();
    repeat (4) @(negedge clk);
    check("calc_busy", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_busy",      longint'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", longint'(in_ready), 1);
    @(negedge clk);
    load_x1();
    push_expected(); send_frame(); drain(-1);

    // random frames against the model, small and large amplitude
    random_frame(12); push_expected(); send_frame(); drain(5);
    random_frame(8);  push_expected(); send_frame(); drain(-1);
    random_frame(1);  push_expected(); send_frame(); drain(-1);

    check("sb_final_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
